// File: rtl/cam_rnd_victim_sel.sv
// cam_rnd_victim_sel
// Picks a replacement victim way for a CAM. A free way (not valid and not
// locked) always wins, lowest index first. Otherwise a pseudo-random
// starting way drawn from a 16-bit Galois LFSR is used, stepping upward
// past locked ways. If every way is locked, the grant reports NoVictim.
//
// Ports
//   Clk      : sole clock, rising edge
//   Rst      : synchronous active-high reset
//   Req      : victim request, only looked at while idle
//   Valid    : per-way occupied flags
//   Lock     : per-way non-replaceable flags
//   Gnt      : one-cycle pulse, Idx/NoVictim meaningful with it
//   Idx      : selected victim way, held until the next grant
//   NoVictim : all ways locked (qualified by Gnt)
//   Busy     : high while a search is in progress
//   Rnd      : current LFSR state (debug/verification)
module cam_rnd_victim_sel #(
  parameter int          NWAYS = 4,
  parameter int          R     = $clog2(NWAYS),
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req,
  input  logic [NWAYS-1:0] Valid,
  input  logic [NWAYS-1:0] Lock,
  output logic             Gnt,
  output logic [R-1:0]     Idx,
  output logic             NoVictim,
  output logic             Busy,
  output logic [15:0]      Rnd
);

  // An all-zero seed would lock the LFSR at zero forever.
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("cam_rnd_victim_sel: SEED must be non-zero");
  end

  if (NWAYS < 2 || NWAYS > 64) begin : g_bad_nways
    $error("cam_rnd_victim_sel: NWAYS must be in 2..64");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  // Rnd < 2^16 and NWAYS <= 2^R, so the product fits in 16+R bits and
  // its top R bits are floor(Rnd*NWAYS/65536), always below NWAYS.
  localparam int PW = 16 + R;

  state_t           state;
  state_t           state_next;
  logic [15:0]      lfsr_next;
  logic [PW-1:0]    prod;
  logic [R-1:0]     mod_q;
  logic [R-1:0]     cand;
  logic [R-1:0]     cand_next;
  logic [NWAYS-1:0] valid_q;
  logic [NWAYS-1:0] lock_q;
  logic             capture;
  logic             gnt_next;
  logic             nov_next;
  logic [R-1:0]     idx_next;
  logic             free_hit;
  logic [R-1:0]     free_idx;

  // Galois step; a zero state (only reachable through an upset) reloads SEED.
  always_comb begin
    if (Rnd == 16'h0000) begin
      lfsr_next = SEED;
    end else begin
      lfsr_next = (Rnd >> 1) ^ (Rnd[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign prod = PW'(Rnd) * PW'(NWAYS);

  // Lowest-index way that is neither occupied nor locked. Scanning downward
  // lets the last hit, i.e. the lowest index, win.
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!valid_q[i] && !lock_q[i]) begin
        free_hit = 1'b1;
        free_idx = R'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cand_next  = cand;
    capture    = 1'b0;
    gnt_next   = 1'b0;
    nov_next   = 1'b0;
    idx_next   = Idx;
    case (state)
      IDLE: begin
        if (Req) begin
          capture    = 1'b1;
          cand_next  = mod_q;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (free_hit) begin
          gnt_next   = 1'b1;
          idx_next   = free_idx;
          state_next = IDLE;
        end else if (&lock_q) begin
          gnt_next   = 1'b1;
          nov_next   = 1'b1;
          idx_next   = '0;
          state_next = IDLE;
        end else if (!lock_q[cand]) begin
          gnt_next   = 1'b1;
          idx_next   = cand;
          state_next = IDLE;
        end else begin
          // Not every way is locked, so this walk terminates within NWAYS-1 steps.
          cand_next = (cand == R'(NWAYS - 1)) ? '0 : cand + R'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rnd      <= SEED;
      mod_q    <= '0;
      cand     <= '0;
      valid_q  <= '0;
      lock_q   <= '0;
      Gnt      <= 1'b0;
      Idx      <= '0;
      NoVictim <= 1'b0;
    end else begin
      Rnd      <= lfsr_next;
      mod_q    <= prod[PW-1 -: R];
      cand     <= cand_next;
      Gnt      <= gnt_next;
      Idx      <= idx_next;
      NoVictim <= nov_next;
      if (capture) begin
        valid_q <= Valid;
        lock_q  <= Lock;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule
